uncached_bridge: RTL and testbench
==================================

Name: uncached_bridge

Overview:
- Downstream consumer of the PMA lookup on the data path.
- Accepts core load/store requests routed to the uncached path, together with the PMA attributes for the request address.
- Faults accesses to non-memory regions without touching the bus. Turns all other requests into single-beat peripheral bus transactions, with a timeout guard.
- Sits between the LSU uncached port and the peripheral interconnect (UART, SPI, GPIO, CLINT, VGA framebuffer, ...).

Parameters:
- XLEN, 32, data/address width
- TIMEOUT_CYC, 256, maximum cycles waiting for bus ack/err before raising an error (must be >= 2)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- req_valid_i  input  1  request valid from LSU uncached port
- req_ready_o  output  1  bridge can accept a request
- req_addr_i  input  XLEN  byte address
- req_we_i  input  1  1 = store, 0 = load
- req_wdata_i  input  XLEN  store data
- req_be_i  input  XLEN/8  byte enables
- pma_uncached_i  input  1  PMA uncached attribute for req_addr_i (combinational, same cycle)
- pma_memregion_i  input  1  PMA valid-region attribute for req_addr_i (combinational, same cycle)
- rsp_valid_o  output  1  one-cycle response strobe
- rsp_rdata_o  output  XLEN  load data (0 for stores and errors)
- rsp_err_o  output  1  access fault (qualified by rsp_valid_o)
- bus_req_o  output  1  peripheral bus request, held until ack/err/timeout
- bus_addr_o  output  XLEN  registered request address
- bus_we_o  output  1  registered write enable
- bus_wdata_o  output  XLEN  registered store data
- bus_be_o  output  XLEN/8  registered byte enables
- bus_ack_i  input  1  transaction complete
- bus_rdata_i  input  XLEN  read data, valid with bus_ack_i
- bus_err_i  input  1  slave error

Behaviour:
- Clocking: one clock, clk_i. rst_i is asynchronous, active-high.
- Reset: state IDLE; req_ready_o=1, all other outputs 0, counter 0. Reset mid-transaction drops the request with no response. bus_req_o falls asynchronously with rst_i.
- FSM states: IDLE, BUS, RESP. Only one transaction is outstanding at a time.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr/we/wdata/be.
  - Fault condition: pma_memregion_i=0 or req_be_i==0. Go to RESP with err=1, rdata=0. No bus activity.
  - Otherwise: go to BUS, clear counter.
  - pma_uncached_i is latched for debug only; the value 0 does not change behaviour.
- BUS:
  - req_ready_o=0. bus_req_o=1, and all bus_* fields stay stable until the transaction ends.
  - Counter increments every cycle.
  - bus_err_i=1: go to RESP with err=1. If bus_ack_i is asserted in the same cycle, err wins.
  - bus_ack_i=1 (no err): go to RESP with err=0. rdata=bus_rdata_i for loads, 0 for stores.
  - Counter reaches TIMEOUT_CYC-1 with no ack/err: go to RESP with err=1, and bus_req_o drops. An ack in that same cycle wins over the timeout (normal response).
- RESP:
  - rsp_valid_o=1 for exactly one cycle, with registered rdata/err. Then go to IDLE.
  - req_ready_o=0 in RESP.
  - No response backpressure.
- Latency:
  - Fault path: request accepted at cycle N, rsp_valid_o at N+1.
  - Bus path: bus_req_o first high at N+1. Ack at cycle M gives rsp_valid_o at M+1.
  - Minimum bus latency: ack at N+1 gives response at N+2.
- Back-to-back: the next request can be accepted the cycle after RESP. Throughput is at most one request per 2 cycles on the fault path and one per 3 cycles on the bus path.
- Widths: counter is $clog2(TIMEOUT_CYC) bits, with no wrap (it is cleared on entering BUS). rsp_rdata_o and rsp_err_o are 0 whenever rsp_valid_o=0.

Test Plan:
- Load 0x2000_0004, be=0xF, memregion=1; slave acks 3 cycles after bus_req_o rises with rdata 0xDEAD_BEEF -> bus_addr_o=0x2000_0004, bus_we_o=0; one rsp_valid_o with rdata 0xDEAD_BEEF, err=0, one cycle after ack.
- Store 0x2000_4000, wdata 0x0000_00A5, be=0x1; ack 1 cycle after bus_req_o rises -> bus_wdata_o/bus_be_o stable for the whole request; rsp err=0, rdata=0; req_ready_o returns to 1 the cycle after rsp_valid_o.
- Load 0x2000_A000 with memregion=0 -> bus_req_o never asserted; rsp_valid_o on the next cycle with err=1, rdata=0. Repeat with be=0 at 0x2000_0000 -> same fault response.
- Slave never responds, TIMEOUT_CYC=8 -> bus_req_o high exactly 8 cycles, then rsp err=1; next request accepted normally.
- bus_ack_i and bus_err_i together -> err=1. Ack arriving in the timeout cycle -> err=0 with the acked data.
- rst_i asserted 2 cycles into BUS -> bus_req_o low immediately (asynchronously), no rsp_valid_o; after release req_ready_o=1 and a fresh load completes correctly.

Source files
------------

// File: rtl/uncached_bridge_if.sv
// uncached_bridge_if: LSU request/response, PMA attributes and peripheral bus signals; slave = bridge side, master = LSU/interconnect side
interface uncached_bridge_if #(parameter int XLEN = 32);
  logic req_valid;
  logic req_ready;
  logic [XLEN-1:0] req_addr;
  logic req_we;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN/8-1:0] req_be;
  logic pma_uncached;
  logic pma_memregion;
  logic rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic rsp_err;
  logic bus_req;
  logic [XLEN-1:0] bus_addr;
  logic bus_we;
  logic [XLEN-1:0] bus_wdata;
  logic [XLEN/8-1:0] bus_be;
  logic bus_ack;
  logic [XLEN-1:0] bus_rdata;
  logic bus_err;
  logic dbg_uncached;
  modport slave (
    input req_valid, req_addr, req_we, req_wdata, req_be, pma_uncached, pma_memregion, bus_ack, bus_rdata, bus_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_addr, bus_we, bus_wdata, bus_be, dbg_uncached
  );
  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, pma_uncached, pma_memregion, bus_ack, bus_rdata, bus_err,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_addr, bus_we, bus_wdata, bus_be, dbg_uncached
  );
endinterface

// File: rtl/uncached_bridge.sv
// uncached_bridge: faults non-memory/empty-be requests, else runs one single-beat bus transaction with timeout; ports clk_i, rst_i (async high), ub (uncached_bridge_if.slave)
module uncached_bridge #(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input logic clk_i,
  input logic rst_i,
  uncached_bridge_if.slave ub
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] rdata_q;
  logic err_q;
  logic fault, timeout, done;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    fault = !ub.pma_memregion || ub.req_be == '0;
    timeout = cnt == CW'(TIMEOUT_CYC - 1);
    done = ub.bus_ack || ub.bus_err || timeout;
    state_nx = state == IDLE ? (ub.req_valid ? (fault ? RESP : BUS) : IDLE)
             : state == BUS ? (done ? RESP : BUS)
             : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      ub.bus_addr <= '0;
      ub.bus_we <= 1'b0;
      ub.bus_wdata <= '0;
      ub.bus_be <= '0;
      ub.dbg_uncached <= 1'b0;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && ub.req_valid) begin
      ub.bus_addr <= ub.req_addr;
      ub.bus_we <= ub.req_we;
      ub.bus_wdata <= ub.req_wdata;
      ub.bus_be <= ub.req_be;
      ub.dbg_uncached <= ub.pma_uncached;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= fault;
    end else if (state == BUS) begin
      cnt <= cnt + 1'b1;
      err_q <= ub.bus_err || (!ub.bus_ack && timeout);
      rdata_q <= (ub.bus_ack && !ub.bus_err && !ub.bus_we) ? ub.bus_rdata : '0;
    end
  assign ub.req_ready = state == IDLE;
  assign ub.bus_req = state == BUS;
  assign ub.rsp_valid = state == RESP;
  assign ub.rsp_rdata = state == RESP ? rdata_q : '0;
  assign ub.rsp_err = state == RESP && err_q;
endmodule

// File: tb/tb_uncached_bridge.sv
// tb_uncached_bridge: directed and randomized checks of uncached_bridge against a transaction-level reference model
module tb_uncached_bridge;
  localparam int T = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  uncached_bridge_if #(.XLEN(32)) ub ();
  uncached_bridge #(.XLEN(32), .TIMEOUT_CYC(T)) dut (.clk_i(clk), .rst_i(rst), .ub(ub.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xact(input logic [31:0] addr, input logic we, input logic [31:0] wd, input logic [31:0] rd,
                      input logic [3:0] be, input logic mem, input int resp_at, input logic back, input logic berr);
    int exp_bus, exp_lat, bus_hi, lat;
    logic exp_err, got;
    logic [31:0] exp_rd;
    if (!mem || be == 4'h0) begin
      exp_bus = 0; exp_lat = 0; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (resp_at >= 1 && resp_at <= T && (back || berr)) begin
      exp_bus = resp_at; exp_lat = resp_at; exp_err = berr; exp_rd = (berr || we) ? 32'h0 : rd;
    end else begin
      exp_bus = T; exp_lat = T; exp_err = 1'b1; exp_rd = 32'h0;
    end
    @(negedge clk);
    chk("req_ready_idle", ub.req_ready, 1);
    ub.req_valid = 1'b1; ub.req_addr = addr; ub.req_we = we; ub.req_wdata = wd; ub.req_be = be;
    ub.pma_memregion = mem; ub.pma_uncached = 1'($urandom);
    @(posedge clk);
    #1;
    ub.req_valid = 1'b0; ub.req_addr = $urandom; ub.req_we = 1'($urandom); ub.req_wdata = $urandom;
    ub.req_be = 4'($urandom); ub.pma_memregion = 1'($urandom);
    ub.bus_rdata = rd;
    got = 1'b0; bus_hi = 0; lat = -1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      ub.bus_ack = 1'b0; ub.bus_err = 1'b0;
      if (ub.rsp_valid) begin
        got = 1'b1; lat = c;
        chk("rsp_rdata", ub.rsp_rdata, exp_rd);
        chk("rsp_err", ub.rsp_err, exp_err);
        chk("bus_req_in_resp", ub.bus_req, 0);
        chk("req_ready_in_resp", ub.req_ready, 0);
      end else if (ub.bus_req) begin
        bus_hi++;
        chk("bus_addr", ub.bus_addr, addr);
        chk("bus_we", ub.bus_we, we);
        chk("bus_wdata", ub.bus_wdata, wd);
        chk("bus_be", ub.bus_be, be);
        chk("req_ready_in_bus", ub.req_ready, 0);
        if (bus_hi == resp_at) begin
          ub.bus_ack = back; ub.bus_err = berr;
        end
      end
    end
    ub.bus_ack = 1'b0; ub.bus_err = 1'b0;
    chk("rsp_seen", got, 1);
    chk("rsp_latency", lat, exp_lat);
    chk("bus_req_cycles", bus_hi, exp_bus);
    @(negedge clk);
    chk("rsp_one_cycle", ub.rsp_valid, 0);
    chk("rsp_err_idle", ub.rsp_err, 0);
    chk("rsp_rdata_idle", ub.rsp_rdata, 0);
    chk("req_ready_after", ub.req_ready, 1);
  endtask
  initial begin
    ub.req_valid = 1'b0; ub.req_addr = '0; ub.req_we = 1'b0; ub.req_wdata = '0; ub.req_be = '0;
    ub.pma_uncached = 1'b0; ub.pma_memregion = 1'b0; ub.bus_ack = 1'b0; ub.bus_err = 1'b0; ub.bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", ub.req_ready, 1);
    chk("rst_bus_req", ub.bus_req, 0);
    chk("rst_rsp_valid", ub.rsp_valid, 0);
    chk("rst_rsp_rdata", ub.rsp_rdata, 0);
    chk("rst_rsp_err", ub.rsp_err, 0);
    chk("rst_bus_addr", ub.bus_addr, 0);
    rst = 1'b0;
    xact(32'h2000_0004, 1'b0, 32'h0, 32'hDEAD_BEEF, 4'hF, 1'b1, 4, 1'b1, 1'b0);
    xact(32'h2000_4000, 1'b1, 32'h0000_00A5, 32'h1234_5678, 4'h1, 1'b1, 2, 1'b1, 1'b0);
    xact(32'h2000_A000, 1'b0, 32'h0, 32'hCAFE_0000, 4'hF, 1'b0, 1, 1'b1, 1'b0);
    xact(32'h2000_0000, 1'b0, 32'h0, 32'hCAFE_0001, 4'h0, 1'b1, 1, 1'b1, 1'b0);
    xact(32'h2000_0010, 1'b0, 32'h0, 32'h5555_AAAA, 4'hF, 1'b1, 0, 1'b0, 1'b0);
    xact(32'h2000_0014, 1'b0, 32'h0, 32'h0BAD_F00D, 4'hF, 1'b1, 2, 1'b1, 1'b0);
    xact(32'h2000_0018, 1'b0, 32'h0, 32'h1111_2222, 4'h3, 1'b1, 2, 1'b1, 1'b1);
    xact(32'h2000_001C, 1'b0, 32'h0, 32'h7777_8888, 4'hF, 1'b1, T, 1'b1, 1'b0);
    xact(32'h2000_0020, 1'b1, 32'h9999_0000, 32'h3333_4444, 4'hC, 1'b1, T, 1'b0, 1'b1);
    @(negedge clk);
    ub.req_valid = 1'b1; ub.req_addr = 32'h2000_0100; ub.req_we = 1'b0; ub.req_be = 4'hF; ub.pma_memregion = 1'b1;
    @(posedge clk);
    #1;
    ub.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_bus_req", ub.bus_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bus_req", ub.bus_req, 0);
    chk("async_rst_rsp_valid", ub.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", ub.rsp_valid, 0);
      chk("post_rst_ready", ub.req_ready, 1);
    end
    xact(32'h2000_0200, 1'b0, 32'h0, 32'hFEED_FACE, 4'hF, 1'b1, 3, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] be;
      logic mem, we, back, berr;
      be = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      mem = $urandom_range(0, 3) != 0;
      we = 1'($urandom);
      back = 1'($urandom);
      berr = $urandom_range(0, 3) == 0;
      xact($urandom, we, $urandom, $urandom, be, mem, int'($urandom_range(0, T + 2)), back, berr);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
